// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoding single-port RAM behind the SPI slave
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       wr_err,
  output logic       rd_err
);

  typedef enum logic {IDLE = 1'b0, RD_HOLD = 1'b1} state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_addr_ok;
  logic                 rd_addr_ok;
  state_t               state;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 do_write;
  logic                 do_read;

  assign cmd          = din[9:8];
  assign payload_addr = din[ADDR_SIZE-1:0];
  assign do_write     = rx_valid && (cmd == CMD_WR_DATA) && wr_addr_ok;
  assign do_read      = rx_valid && (cmd == CMD_RD_DATA) && rd_addr_ok;
  assign tx_valid     = (state == RD_HOLD);

  // Storage is never reset; an edge that coincides with rst must not write.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dout       <= 8'h00;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr    <= payload_addr;
            wr_addr_ok <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_addr_ok) begin
              if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_SIZE'(1);
            end else begin
              wr_err <= 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr    <= payload_addr;
            rd_addr_ok <= 1'b1;
          end
          default: begin
            if (rd_addr_ok) begin
              dout <= mem[rd_addr];
              if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_SIZE'(1);
            end else begin
              rd_err <= 1'b1;
            end
          end
        endcase
        state <= do_read ? RD_HOLD : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - directed and random checks of spi_ram_ctrl against a command-level model
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din_a = '0, din_b = '0;
  logic       rxv_a = 1'b0, rxv_b = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, we_a, we_b, re_a, re_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
    .clk(clk), .rst(rst), .din(din_a), .rx_valid(rxv_a),
    .dout(dout_a), .tx_valid(tx_a), .wr_err(we_a), .rd_err(re_a)
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (
    .clk(clk), .rst(rst), .din(din_b), .rx_valid(rxv_b),
    .dout(dout_b), .tx_valid(tx_b), .wr_err(we_b), .rd_err(re_b)
  );

  // Reference state per instance: 0 = auto-increment, 1 = fixed pointers
  int         m_wa [2];
  int         m_ra [2];
  bit         m_wok [2];
  bit         m_rok [2];
  logic [7:0] m_dout [2];
  bit         m_dk [2];
  bit         m_tx [2];
  bit         m_we [2];
  bit         m_re [2];
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_wa[s] = 0; m_ra[s] = 0; m_wok[s] = 0; m_rok[s] = 0;
      m_dout[s] = 8'h00; m_dk[s] = 1; m_tx[s] = 0; m_we[s] = 0; m_re[s] = 0;
    end
  endtask

  task automatic model_cmd(input int s, input int c, input int p);
    int step;
    step = (s == 0) ? 1 : 0;
    m_we[s] = 0; m_re[s] = 0; m_tx[s] = 0;
    case (c)
      0: begin m_wa[s] = p; m_wok[s] = 1; end
      1: if (m_wok[s]) begin
           m_mem[s][m_wa[s]] = p[7:0]; m_known[s][m_wa[s]] = 1;
           m_wa[s] = (m_wa[s] + step) % 256;
         end else m_we[s] = 1;
      2: begin m_ra[s] = p; m_rok[s] = 1; end
      default: if (m_rok[s]) begin
           m_dout[s] = m_mem[s][m_ra[s]]; m_dk[s] = m_known[s][m_ra[s]];
           m_tx[s] = 1;
           m_ra[s] = (m_ra[s] + step) % 256;
         end else m_re[s] = 1;
    endcase
  endtask

  task automatic check_outputs(input int s, input string tag);
    logic [7:0] d;
    logic t, we, re;
    d  = (s == 0) ? dout_a : dout_b;
    t  = (s == 0) ? tx_a : tx_b;
    we = (s == 0) ? we_a : we_b;
    re = (s == 0) ? re_a : re_b;
    if (m_dk[s]) chk({tag, " dout"}, d, m_dout[s]);
    chk({tag, " tx_valid"}, {7'b0, t}, {7'b0, m_tx[s]});
    chk({tag, " wr_err"}, {7'b0, we}, {7'b0, m_we[s]});
    chk({tag, " rd_err"}, {7'b0, re}, {7'b0, m_re[s]});
  endtask

  // Called at a falling edge; presents one command for one rising edge.
  task automatic do_cmd(input int s, input int c, input int p, input string tag);
    logic [1:0] cc;
    logic [7:0] pp;
    cc = c[1:0];
    pp = p[7:0];
    if (s == 0) begin din_a = {cc, pp}; rxv_a = 1'b1; end
    else        begin din_b = {cc, pp}; rxv_b = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    rxv_a = 1'b0; rxv_b = 1'b0;
    din_a = 'x;   din_b = 'x;
    model_cmd(s, c, p);
    m_we[1-s] = 0; m_re[1-s] = 0;
    check_outputs(s, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        m_we[s] = 0; m_re[s] = 0;
        check_outputs(s, tag);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) m_known[s][a] = 0;
    model_reset();
    din_a = 'x; din_b = 'x;
    @(negedge clk);
    @(negedge clk);
    check_outputs(0, "reset a");
    check_outputs(1, "reset b");
    rst = 1'b0;

    do_cmd(0, 0, 8'h10, "t1 wa");
    do_cmd(0, 1, 8'hA5, "t1 wd");
    do_cmd(0, 2, 8'h10, "t1 ra");
    do_cmd(0, 3, 0,     "t1 rd");
    chk("t1 dout const", dout_a, 8'hA5);
    chk("t1 tx const", {7'b0, tx_a}, 8'h01);
    idle(3, "t1 hold");

    do_cmd(0, 0, 8'hFF, "t2 wa");
    do_cmd(0, 1, 8'h11, "t2 wd0");
    do_cmd(0, 1, 8'h22, "t2 wd1");
    do_cmd(0, 2, 8'hFF, "t2 ra");
    do_cmd(0, 3, 0,     "t2 rd0");
    chk("t2 first const", dout_a, 8'h11);
    do_cmd(0, 3, 0,     "t2 rd1");
    chk("t2 wrapped const", dout_a, 8'h22);

    do_cmd(0, 0, 8'h40, "t4 wa drops tx");
    chk("t4 dout kept", dout_a, 8'h22);
    chk("t4 tx const", {7'b0, tx_a}, 8'h00);

    do_cmd(1, 0, 8'h05, "t6 wa");
    do_cmd(1, 1, 8'h3C, "t6 wd");
    do_cmd(1, 1, 8'hC3, "t6 wd overwrite");
    do_cmd(1, 2, 8'h05, "t6 ra");
    for (int i = 0; i < 3; i++) begin
      do_cmd(1, 3, 0, "t6 rd");
      chk("t6 fixed const", dout_b, 8'hC3);
    end

    do_cmd(0, 2, 8'h10, "t5 ra");
    do_cmd(0, 3, 0,     "t5 rd");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5 async dout", dout_a, 8'h00);
    chk("t5 async tx", {7'b0, tx_a}, 8'h00);
    chk("t5 async dout b", dout_b, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(0, 3, 0, "t3 rd no addr");
    chk("t3 rd_err const", {7'b0, re_a}, 8'h01);
    idle(1, "t3 rd_err clear");
    do_cmd(0, 1, 8'h5C, "t3 wd no addr");
    chk("t3 wr_err const", {7'b0, we_a}, 8'h01);
    idle(1, "t3 wr_err clear");
    do_cmd(0, 2, 8'h00, "t3 ra0");
    do_cmd(0, 3, 0,     "t3 rd0");
    n_cmp++;
    assert (dout_a !== 8'h5C) else begin
      n_bad++;
      $error("FAIL t3 dropped write: observed %h expected not %h", dout_a, 8'h5C);
    end

    for (int i = 0; i < 300; i++) begin
      int s, c, p;
      s = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 3));
      p = (c[0] == 1'b0 && $urandom_range(0, 3) != 0) ? int'($urandom_range(0, 15))
                                                      : int'($urandom_range(0, 255));
      do_cmd(s, c, p, "rand");
      if ($urandom_range(0, 7) == 0) idle(1, "rand idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
